// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: oversampled clock/data, 11-bit frame deframing with
// start/parity/stop checks and mid-frame timeout, feeding a scan-code FIFO.
module ps2_kbd_rx #(
    parameter int FIFO_AW = 3,
    parameter int TIMEOUT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic [7:0] key,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t             state, state_nxt;
    logic               clk_s1, clk_s2, clk_s3;
    logic               data_s1, data_s2;
    logic               fall;
    logic [9:0]         sr;
    logic [3:0]         bitcnt;
    logic [TW-1:0]      idle_cnt;
    logic               timeout;
    logic               frame_ok;
    logic               push;
    logic               rd_q, rd_q2;
    logic               pop;
    logic               do_push, do_pop;
    logic               full;
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   count;
    logic [7:0]         mem [DEPTH];

    // Synchronisers idle high so reset never manufactures a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {clk_s1, clk_s2, clk_s3} <= 3'b111;
            {data_s1, data_s2}       <= 2'b11;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall    = clk_s3 & ~clk_s2;
    assign timeout = (state == SHIFT) && !fall && (idle_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall && !data_s2) state_nxt = SHIFT;
            SHIFT: begin
                if (fall && bitcnt == 4'd9) state_nxt = CHECK;
                else if (timeout)           state_nxt = IDLE;
            end
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame is good when data+parity has odd weight and the stop bit is high
    always_comb begin
        frame_ok  = (^sr[8:0]) & sr[9];
        push      = (state == CHECK) & frame_ok;
        frame_err = ((state == CHECK) & ~frame_ok) | timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            bitcnt   <= '0;
            idle_cnt <= '0;
        end else begin
            if (state == IDLE && fall) bitcnt <= '0;
            if (state == SHIFT && fall) begin
                sr     <= {data_s2, sr[9:1]};
                bitcnt <= bitcnt + 4'd1;
            end
            if (fall || state != SHIFT) idle_cnt <= '0;
            else                        idle_cnt <= idle_cnt + TW'(1);
        end
    end

    // Registered strobe edge: one pop per bus read however long rd is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= 1'b0;
            rd_q2 <= 1'b0;
        end else begin
            rd_q  <= rd;
            rd_q2 <= rd_q;
        end
    end

    assign pop     = rd_q & ~rd_q2;
    assign ready   = (count != '0);
    assign full    = count[FIFO_AW];
    assign do_pop  = pop & ready;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + FIFO_AW'(1);
            if (do_pop)  rptr <= rptr + FIFO_AW'(1);
            if (do_push && !do_pop)      count <= count + (FIFO_AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (FIFO_AW+1)'(1);
            if (push && !do_push) overflow <= 1'b1;
            else if (do_pop)      overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= sr[7:0];
    end

    assign key = ready ? mem[rptr] : 8'h00;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: PS/2 frames driven at pin level, compared against a
// queue-based model of the scan-code FIFO, overflow flag and error pulses.
module tb_ps2_kbd_rx;
    localparam int FIFO_AW = 3;
    localparam int TO      = 300;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd;
    logic [7:0] key;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    ps2_kbd_rx #(.FIFO_AW(FIFO_AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd),
        .key(key), .ready(ready), .overflow(overflow), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         half     = 10;
    int         err_seen = 0;
    int         exp_err  = 0;
    logic [7:0] q[$];
    logic       exp_ovf  = 1'b0;

    always @(negedge clk) if (frame_err) err_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // rd_at_last raises rd so the resulting pop lands in the CHECK cycle
    task automatic send_bits(input logic [10:0] bits, input int nbits, input logic rd_at_last);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(half);
            ps2_clk = 1'b0;
            if (i == nbits - 1 && rd_at_last) begin
                cyc(2);
                rd = 1'b1;
                cyc(half - 2);
            end else begin
                cyc(half);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic compare_state(input string tag);
        check({tag, ".ready"}, ready, q.size() != 0);
        check({tag, ".key"}, key, q.size() != 0 ? q[0] : 8'h00);
        check({tag, ".ovf"}, overflow, exp_ovf);
        check({tag, ".err"}, err_seen, exp_err);
    endtask

    task automatic frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                         input logic rd_at_last, input string tag);
        half = $urandom_range(6, 20);
        send_bits(mk(b, bad_par, bad_stop), 11, rd_at_last);
        cyc(6);
        rd = 1'b0;
        if (bad_par || bad_stop) begin
            exp_err++;
        end else if (rd_at_last && q.size() != 0) begin
            void'(q.pop_front());
            q.push_back(b);
            exp_ovf = 1'b0;
        end else if (q.size() < DEPTH) begin
            q.push_back(b);
        end else begin
            exp_ovf = 1'b1;
        end
        cyc(2);
        compare_state(tag);
    endtask

    task automatic do_read(input int hold, input string tag);
        rd = 1'b1;
        cyc(hold);
        rd = 1'b0;
        cyc(4);
        if (q.size() != 0) begin
            void'(q.pop_front());
            exp_ovf = 1'b0;
        end
        compare_state(tag);
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
        cyc(3);
        compare_state("reset");
        rst = 1'b0;
        cyc(5);

        frame(8'h1C, 1'b0, 1'b0, 1'b0, "good_1c");
        do_read(1, "read_1c");
        frame(8'h1C, 1'b1, 1'b0, 1'b0, "badpar_1c");
        frame(8'h1C, 1'b0, 1'b1, 1'b0, "badstop_1c");

        // Lone falling edge with data high is a glitch, not an error
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        cyc(10);
        ps2_clk  = 1'b1;
        cyc(10);
        compare_state("glitch");

        for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b0, 1'b0, "fill9");
        for (int i = 0; i < 8; i++) do_read(3, "drain8");

        half = 10;
        send_bits(mk(8'hF0, 1'b0, 1'b0), 5, 1'b0);
        cyc(TO + 20);
        exp_err++;
        compare_state("timeout");
        frame(8'hF0, 1'b0, 1'b0, 1'b0, "after_to");
        do_read(2, "read_f0");

        for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, "fill8");
        frame(8'h18, 1'b0, 1'b0, 1'b1, "push_pop_full");
        for (int i = 0; i < 8; i++) do_read(1, "drain_pp");

        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            int         kind;
            b    = 8'($urandom);
            kind = $urandom_range(0, 5);
            frame(b, kind == 0, kind == 1, 1'b0, "rand_frame");
            if ($urandom_range(0, 2) == 0) do_read($urandom_range(1, 4), "rand_read");
        end

        half = 10;
        send_bits(mk(8'h33, 1'b0, 1'b0), 6, 1'b0);
        rst = 1'b1;
        q.delete();
        exp_ovf = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(5);
        compare_state("midreset");
        frame(8'h5A, 1'b0, 1'b0, 1'b0, "after_rst");
        do_read(1, "read_5a");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
